// File: rtl/fft_pkg.sv
// Shared FFT types: twiddle mode encoding, a wide complex helper and the (-j)^q rotation.
package fft_pkg;

  typedef enum logic [1:0] {
    TW_NONE    = 2'd0,
    TW_HALF    = 2'd1,
    TW_QUARTER = 2'd2
  } tw_mode_e;

  localparam int CPLX_W = 32;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  // Multiply by (-j)^q using swaps and negations only.
  function automatic cplx_t rot_nj(input cplx_t x, input logic [1:0] q);
    cplx_t r;
    case (q)
      2'd0:    begin r.re = x.re;  r.im = x.im;  end
      2'd1:    begin r.re = x.im;  r.im = -x.re; end
      2'd2:    begin r.re = -x.re; r.im = -x.im; end
      default: begin r.re = -x.im; r.im = x.re;  end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bfly_lane.sv
// One butterfly lane, purely combinational: sign-extended add/sub feeding S1, and rotate plus
// optional round-half-up/saturate (BFLY_SCALE_EN) feeding S2.
module bfly_lane
  import fft_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = IN_W + 1
) (
  input  logic signed [IN_W-1:0]  a_re,
  input  logic signed [IN_W-1:0]  a_im,
  input  logic signed [IN_W-1:0]  b_re,
  input  logic signed [IN_W-1:0]  b_im,
  output logic signed [IN_W:0]    ab_sum_re,
  output logic signed [IN_W:0]    ab_sum_im,
  output logic signed [IN_W:0]    ab_dif_re,
  output logic signed [IN_W:0]    ab_dif_im,
  input  logic signed [IN_W:0]    p_sum_re,
  input  logic signed [IN_W:0]    p_sum_im,
  input  logic signed [IN_W:0]    p_dif_re,
  input  logic signed [IN_W:0]    p_dif_im,
  input  logic [1:0]              q,
  output logic signed [OUT_W-1:0] fin_sum_re,
  output logic signed [OUT_W-1:0] fin_sum_im,
  output logic signed [OUT_W-1:0] fin_dif_re,
  output logic signed [OUT_W-1:0] fin_dif_im
);

  // One extra bit of headroom makes both sum and difference exact.
  assign ab_sum_re = {a_re[IN_W-1], a_re} + {b_re[IN_W-1], b_re};
  assign ab_sum_im = {a_im[IN_W-1], a_im} + {b_im[IN_W-1], b_im};
  assign ab_dif_re = {a_re[IN_W-1], a_re} - {b_re[IN_W-1], b_re};
  assign ab_dif_im = {a_im[IN_W-1], a_im} - {b_im[IN_W-1], b_im};

`ifdef BFLY_SCALE_EN
  localparam logic signed [CPLX_W-1:0] SAT_HI = CPLX_W'((1 <<< (IN_W - 1)) - 1);
  localparam logic signed [CPLX_W-1:0] SAT_LO = -SAT_HI - 1;

  function automatic logic [OUT_W-1:0] fmt(input logic signed [CPLX_W-1:0] x);
    logic signed [CPLX_W-1:0] y;
    y = (x + 1) >>> 1;
    if (y > SAT_HI)
      y = SAT_HI;
    else if (y < SAT_LO)
      y = SAT_LO;
    return y[OUT_W-1:0];
  endfunction
`else
  function automatic logic [OUT_W-1:0] fmt(input logic signed [CPLX_W-1:0] x);
    return x[OUT_W-1:0];
  endfunction
`endif

  cplx_t dif_w, rot_w;

  always_comb begin
    dif_w.re = CPLX_W'(p_dif_re);
    dif_w.im = CPLX_W'(p_dif_im);
    rot_w    = rot_nj(dif_w, q);
  end

  assign fin_sum_re = fmt(CPLX_W'(p_sum_re));
  assign fin_sum_im = fmt(CPLX_W'(p_sum_im));
  assign fin_dif_re = fmt(rot_w.re);
  assign fin_dif_im = fmt(rot_w.im);

endmodule

// File: rtl/butterfly_stage_param.sv
// Radix-2 DIF butterfly stage over LANES lanes with beat-indexed trivial twiddle; BFLY_SCALE_EN scales to IN_W.
// Latency 2 cycles (S1 add/sub, S2 twiddle/scale); a stalled output freezes both stages, no skid buffer.
module butterfly_stage_param
  import fft_pkg::*;
#(
  parameter int IN_W      = 9,
  parameter int LANES     = 16,
  parameter int BLOCK_LEN = 16,
  parameter int TW_MODE   = 1,
  parameter int TAIL_LEN  = 17,
`ifdef BFLY_SCALE_EN
  localparam int OUT_W = IN_W
`else
  localparam int OUT_W = IN_W + 1
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0][IN_W-1:0]   in_a_re,
  input  logic [LANES-1:0][IN_W-1:0]   in_a_im,
  input  logic [LANES-1:0][IN_W-1:0]   in_b_re,
  input  logic [LANES-1:0][IN_W-1:0]   in_b_im,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0][OUT_W-1:0]  sum_re,
  output logic [LANES-1:0][OUT_W-1:0]  sum_im,
  output logic [LANES-1:0][OUT_W-1:0]  dif_re,
  output logic [LANES-1:0][OUT_W-1:0]  dif_im,
  output logic                         blk_first,
  output logic                         blk_last,
  output logic                         sr_valid
);

  localparam int BW = $clog2(BLOCK_LEN);
  localparam int TW = $clog2(TAIL_LEN + 1);
  localparam int SW = IN_W + 1;

  logic [BW-1:0] beat_idx, s1_beat;
  logic [TW-1:0] tail_cnt;
  logic          s1_full, s2_full, s2_adv, accept;
  logic [1:0]    q;

  logic [LANES-1:0][SW-1:0]    ab_sum_re, ab_sum_im, ab_dif_re, ab_dif_im;
  logic [LANES-1:0][SW-1:0]    s1_sum_re, s1_sum_im, s1_dif_re, s1_dif_im;
  logic [LANES-1:0][OUT_W-1:0] fin_sum_re, fin_sum_im, fin_dif_re, fin_dif_im;

  assign s2_adv    = s1_full && (!s2_full || out_ready);
  assign in_ready  = !s1_full || s2_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_full;
  assign sr_valid  = tail_cnt != '0;

  // Quadrant derives from the beat index carried alongside the S1 data.
  always_comb begin
    q = 2'd0;
    if (TW_MODE == int'(TW_HALF))
      q = {1'b0, s1_beat[BW-1]};
    else if (TW_MODE == int'(TW_QUARTER))
      q = s1_beat[BW-1 -: 2];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bfly_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane (
      .a_re      (in_a_re[l]),
      .a_im      (in_a_im[l]),
      .b_re      (in_b_re[l]),
      .b_im      (in_b_im[l]),
      .ab_sum_re (ab_sum_re[l]),
      .ab_sum_im (ab_sum_im[l]),
      .ab_dif_re (ab_dif_re[l]),
      .ab_dif_im (ab_dif_im[l]),
      .p_sum_re  (s1_sum_re[l]),
      .p_sum_im  (s1_sum_im[l]),
      .p_dif_re  (s1_dif_re[l]),
      .p_dif_im  (s1_dif_im[l]),
      .q         (q),
      .fin_sum_re(fin_sum_re[l]),
      .fin_sum_im(fin_sum_im[l]),
      .fin_dif_re(fin_dif_re[l]),
      .fin_dif_im(fin_dif_im[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_idx  <= '0;
      tail_cnt  <= '0;
      s1_full   <= 1'b0;
      s2_full   <= 1'b0;
      s1_beat   <= '0;
      s1_sum_re <= '0;
      s1_sum_im <= '0;
      s1_dif_re <= '0;
      s1_dif_im <= '0;
      sum_re    <= '0;
      sum_im    <= '0;
      dif_re    <= '0;
      dif_im    <= '0;
      blk_first <= 1'b0;
      blk_last  <= 1'b0;
    end else begin
      if (accept) begin
        beat_idx  <= beat_idx + 1'b1;
        s1_beat   <= beat_idx;
        s1_sum_re <= ab_sum_re;
        s1_sum_im <= ab_sum_im;
        s1_dif_re <= ab_dif_re;
        s1_dif_im <= ab_dif_im;
      end

      // Tail keeps counting through output stalls.
      if (accept)
        tail_cnt <= TW'(TAIL_LEN);
      else if (tail_cnt != '0)
        tail_cnt <= tail_cnt - 1'b1;

      s1_full <= accept || (s1_full && !s2_adv);

      if (s2_adv) begin
        sum_re    <= fin_sum_re;
        sum_im    <= fin_sum_im;
        dif_re    <= fin_dif_re;
        dif_im    <= fin_dif_im;
        blk_first <= s1_beat == '0;
        blk_last  <= s1_beat == BW'(BLOCK_LEN - 1);
      end

      s2_full <= s2_adv || (s2_full && !out_ready);
    end
  end

endmodule
